stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch counter datapath (m10/m1/s10/s1). It debounces the reset and pause buttons and synchronizes the sel/adj switches. It runs the IDLE/RUN/PAUSE/ADJUST mode machine and generates the single-cycle enables that advance, adjust and clear the counter. It also produces the display blink for adjust mode. It sits between board I/O and the counter, and all counter updates happen on its clock.

---
 rtl/stopwatch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: input conditioning, IDLE/RUN/PAUSE/ADJUST mode
// machine, and the registered enables and blink that drive the m10/m1/s10/s1 counter.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 100000000,
    parameter int FAST_DIV   = 50000000,
    parameter int BLINK_DIV  = 25000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rstB,
    input  logic       pauseB,
    input  logic       sel,
    input  logic       adj,
    output logic       count_en,
    output logic       adj_min_en,
    output logic       adj_sec_en,
    output logic       clr,
    output logic       blink,
    output logic [1:0] state
);

    localparam int TW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
    localparam int FW = (FAST_DIV   > 1) ? $clog2(FAST_DIV)   : 1;
    localparam int BW = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FAST_MAX  = FW'(FAST_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSE  = 2'b10,
        ADJUST = 2'b11
    } mode_t;

    mode_t         state_q, state_n;
    logic [3:0]    in_p0, in_p1;
    logic [1:0]    deb, deb_d, press;
    logic [DW-1:0] dcnt [2];
    logic [TW-1:0] tdiv;
    logic [FW-1:0] fdiv;
    logic [BW-1:0] bdiv;
    logic          rp, pp, sel_s, adj_s;
    logic          adj_start, fast_run, tick_wrap, fast_wrap, blink_wrap;
    logic          count_en_n, adj_min_n, adj_sec_n;

    // stage p0 -> p1: two-flop synchronizers, bit order {adj, sel, pauseB, rstB}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_p0 <= '0;
            in_p1 <= '0;
        end else begin
            in_p0 <= {adj, sel, pauseB, rstB};
            in_p1 <= in_p0;
        end
    end

    assign sel_s = in_p1[2];
    assign adj_s = in_p1[3];

    // debounce and rising-edge press detection; bit 0 = reset button, bit 1 = pause button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb     <= '0;
            deb_d   <= '0;
            press   <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int i = 0; i < 2; i++) begin
                if (in_p1[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_MAX) begin
                    deb[i]  <= in_p1[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    assign rp = press[0];
    assign pp = press[1];

    always_comb begin
        state_n = state_q;
        if (rp) begin
            state_n = adj_s ? ADJUST : IDLE;
        end else if (adj_s && (state_q != ADJUST)) begin
            state_n = ADJUST;
        end else if (!adj_s && (state_q == ADJUST)) begin
            state_n = PAUSE;
        end else if (pp) begin
            case (state_q)
                IDLE:    state_n = RUN;
                RUN:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                default: state_n = state_q;
            endcase
        end

        // a reset press while already adjusting restarts the adjust timing like a fresh entry
        adj_start  = (state_n == ADJUST) && ((state_q != ADJUST) || rp);
        fast_run   = (state_q == ADJUST) && (state_n == ADJUST) && !rp;
        tick_wrap  = (tdiv == TICK_MAX);
        fast_wrap  = (fdiv == FAST_MAX);
        blink_wrap = (bdiv == BLINK_MAX);

        count_en_n = (state_q == RUN) && !rp && !adj_start && tick_wrap;
        adj_min_n  = fast_run && fast_wrap && sel_s;
        adj_sec_n  = fast_run && fast_wrap && !sel_s;
    end

    // stage p1 -> outputs: mode register and registered single-cycle enables
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            clr        <= 1'b0;
            count_en   <= 1'b0;
            adj_min_en <= 1'b0;
            adj_sec_en <= 1'b0;
        end else begin
            state_q    <= state_n;
            clr        <= rp;
            count_en   <= count_en_n;
            adj_min_en <= adj_min_n;
            adj_sec_en <= adj_sec_n;
        end
    end

    // tick divider holds in PAUSE so a resume keeps the partial second
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tdiv <= '0;
        end else if (rp || adj_start) begin
            tdiv <= '0;
        end else if (state_q == RUN) begin
            tdiv <= tick_wrap ? '0 : tdiv + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fdiv  <= '0;
            bdiv  <= '0;
            blink <= 1'b0;
        end else if (!fast_run) begin
            fdiv  <= '0;
            bdiv  <= '0;
            blink <= 1'b0;
        end else begin
            fdiv <= fast_wrap ? '0 : fdiv + FW'(1);
            if (blink_wrap) begin
                bdiv  <= '0;
                blink <= ~blink;
            end else begin
                bdiv <= bdiv + BW'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button/switch activity,
// every cycle compared against an elapsed-time reference model.
module tb_stopwatch_ctrl;

    localparam int TD = 10;
    localparam int FD = 4;
    localparam int BD = 2;
    localparam int DC = 3;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rstB   = 1'b0;
    logic       pauseB = 1'b0;
    logic       sel    = 1'b0;
    logic       adj    = 1'b0;
    logic       count_en, adj_min_en, adj_sec_en, clr, blink;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .TICK_DIV  (TD),
        .FAST_DIV  (FD),
        .BLINK_DIV (BD),
        .DEB_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rstB      (rstB),
        .pauseB    (pauseB),
        .sel       (sel),
        .adj       (adj),
        .count_en  (count_en),
        .adj_min_en(adj_min_en),
        .adj_sec_en(adj_sec_en),
        .clr       (clr),
        .blink     (blink),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Reference model: input histories, stable-run debouncing, elapsed-cycle timing.
    bit [1:0] h_rb, h_pb, h_sel, h_adj;
    bit       lvl_r, lvl_p, prev_r, prev_p, rp_m, pp_m;
    int       run_r, run_p, mode, run_el, adj_el;
    bit       m_clr, m_cnt, m_min, m_sec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        h_rb = '0; h_pb = '0; h_sel = '0; h_adj = '0;
        lvl_r = 0; lvl_p = 0; prev_r = 0; prev_p = 0; rp_m = 0; pp_m = 0;
        run_r = 0; run_p = 0; mode = 0; run_el = 0; adj_el = 0;
        m_clr = 0; m_cnt = 0; m_min = 0; m_sec = 0;
    endtask

    task automatic debounce(input bit s, inout bit lvl, inout int run);
        if (s != lvl) begin
            run++;
            if (run >= DC) begin
                lvl = s;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_step();
        bit adj_s, sel_s, rp, pp, start;
        int nmode;
        adj_s = h_adj[1];
        sel_s = h_sel[1];
        rp    = rp_m;
        pp    = pp_m;
        nmode = mode;
        if (rp)                       nmode = adj_s ? 3 : 0;
        else if (adj_s && mode != 3)  nmode = 3;
        else if (!adj_s && mode == 3) nmode = 2;
        else if (pp && mode == 0)     nmode = 1;
        else if (pp && mode == 1)     nmode = 2;
        else if (pp && mode == 2)     nmode = 1;
        start = (nmode == 3) && (mode != 3 || rp);
        m_clr = rp; m_cnt = 0; m_min = 0; m_sec = 0;
        if (rp || start) run_el = 0;
        else if (mode == 1) begin
            run_el++;
            m_cnt = (run_el % TD) == 0;
        end
        if (nmode != 3 || start) adj_el = 0;
        else begin
            adj_el++;
            if (adj_el % FD == 0) begin
                if (sel_s) m_min = 1;
                else       m_sec = 1;
            end
        end
        mode = nmode;
        rp_m = lvl_r && !prev_r;
        pp_m = lvl_p && !prev_p;
        prev_r = lvl_r;
        prev_p = lvl_p;
        debounce(h_rb[1], lvl_r, run_r);
        debounce(h_pb[1], lvl_p, run_p);
        h_rb  = {h_rb[0],  rstB};
        h_pb  = {h_pb[0],  pauseB};
        h_sel = {h_sel[0], sel};
        h_adj = {h_adj[0], adj};
    endtask

    function automatic logic [6:0] expected();
        bit b;
        b = (mode == 3) && (((adj_el / BD) % 2) == 1);
        return {mode[1:0], m_clr, m_cnt, m_min, m_sec, b};
    endfunction

    task automatic cyc();
        if (!rst) model_reset();
        else      model_step();
        @(posedge clk);
        @(negedge clk);
        check("outs", {state, clr, count_en, adj_min_en, adj_sec_en, blink}, expected());
    endtask

    task automatic press_wait(input logic [1:0] target, output int n);
        pauseB = 1'b1;
        n = 0;
        while (state !== target && n < 40) begin
            if (n == 8) pauseB = 1'b0;
            cyc();
            n++;
        end
        pauseB = 1'b0;
        check("press_state", state, target);
        check("press_lat", n, 2 + DC + 2);
    endtask

    initial begin
        int n, k, m, first, ticks, sum, chg, mins, secs, cnts, tog, clrs;
        logic [1:0] prev_st;
        logic prev_bl;

        model_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_outs", {state, clr, count_en, adj_min_en, adj_sec_en, blink}, 0);
        rst = 1'b1;
        repeat (5) cyc();

        // Start from IDLE with a 20-cycle press, then count ticks
        pauseB = 1'b1;
        n = 0;
        while (state !== 2'b01 && n < 20) begin
            cyc();
            n++;
        end
        check("start_lat", n, 2 + DC + 2);
        first = -1;
        ticks = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i == 14) pauseB = 1'b0;
            cyc();
            if (count_en) begin
                ticks++;
                if (first < 0) first = i;
            end
        end
        check("first_tick", first, TD);
        check("ticks_100", ticks, 10);

        // Pause right after a tick, hold, resume; partial second is kept
        press_wait(2'b10, k);
        sum = 0;
        repeat (30) begin
            cyc();
            sum += count_en;
        end
        check("paused_ticks", sum, 0);
        press_wait(2'b01, n);
        m = 0;
        while (!count_en && m < 20) begin
            cyc();
            m++;
        end
        check("resume_tick", m, TD - k);

        // Short glitches are rejected; a bounced press gives one transition
        repeat (10) cyc();
        for (int len = 1; len <= 2; len++) begin
            pauseB = 1'b1;
            repeat (len) cyc();
            pauseB = 1'b0;
            repeat (10) cyc();
            check("glitch", state, 2'b01);
        end
        chg = 0;
        prev_st = state;
        for (int i = 0; i < 30; i++) begin
            pauseB = (i >= 10) ? 1'b1 : ((i % 2) == 0);
            cyc();
            if (state !== prev_st) chg++;
            prev_st = state;
        end
        check("bounce_trans", chg, 1);
        check("bounce_state", state, 2'b10);
        pauseB = 1'b0;
        repeat (10) cyc();

        // Adjust mode: minutes then seconds, blink, exit to PAUSE
        adj = 1'b1;
        sel = 1'b1;
        mins = 0; secs = 0; cnts = 0;
        repeat (40) begin
            cyc();
            mins += adj_min_en; secs += adj_sec_en; cnts += count_en;
        end
        check("adj_state", state, 2'b11);
        check("adj_mins", mins, 9);
        check("adj_secs_sel1", secs, 0);
        check("adj_no_tick", cnts, 0);
        sel = 1'b0;
        mins = 0; secs = 0; tog = 0;
        prev_bl = blink;
        repeat (20) begin
            cyc();
            mins += adj_min_en; secs += adj_sec_en;
            if (blink !== prev_bl) tog++;
            prev_bl = blink;
        end
        check("adj_secs", secs, 5);
        check("adj_mins_sel0", mins, 0);
        check("blink_toggles", tog, 10);
        adj = 1'b0;
        repeat (5) cyc();
        check("adj_exit_state", state, 2'b10);
        check("adj_exit_blink", blink, 0);

        // Reset press wins over a simultaneous pause press
        press_wait(2'b01, n);
        repeat (12) cyc();
        rstB = 1'b1;
        pauseB = 1'b1;
        clrs = 0;
        repeat (15) begin
            cyc();
            if (clr) begin
                clrs++;
                check("clr_no_tick", count_en, 0);
                check("clr_idle", state, 2'b00);
            end
        end
        check("clr_pulses", clrs, 1);
        rstB = 1'b0;
        pauseB = 1'b0;
        repeat (10) cyc();
        check("after_clr", state, 2'b00);
        adj = 1'b1;
        repeat (6) cyc();
        rstB = 1'b1;
        clrs = 0;
        repeat (12) begin
            cyc();
            if (clr) begin
                clrs++;
                check("clr_adj_state", state, 2'b11);
            end
        end
        check("clr_adj_pulses", clrs, 1);
        rstB = 1'b0;
        repeat (8) cyc();
        adj = 1'b0;
        repeat (6) cyc();

        // Asynchronous reset mid-RUN, no clr or tick afterwards
        press_wait(2'b01, n);
        repeat (13) cyc();
        #2 rst = 1'b0;
        #1 check("async_rst", {state, clr, count_en, adj_min_en, adj_sec_en, blink}, 0);
        repeat (3) cyc();
        rst = 1'b1;
        sum = 0;
        repeat (30) begin
            cyc();
            sum += clr + count_en;
        end
        check("post_rst_quiet", sum, 0);
        check("post_rst_state", state, 2'b00);
        press_wait(2'b01, n);

        // Random activity against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0)  pauseB = ~pauseB;
            if ($urandom_range(0, 149) == 0) rstB   = ~rstB;
            if ($urandom_range(0, 99) == 0)  adj    = ~adj;
            if ($urandom_range(0, 29) == 0)  sel    = ~sel;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
